// File: rtl/i3c_multi_bus_io_if.sv
// Controller-side and pad-side signal bundle for i3c_multi_bus_io.
// The slave modport is the pad glue; the master modport is the controller/pad-ring side.
interface i3c_multi_bus_io_if #(
  parameter int NumBuses = 2
);
  logic [NumBuses-1:0]   bus_en_i;
  logic [NumBuses-1:0]   sel_od_pp_i;
  logic [NumBuses-1:0]   scl_phy_i;
  logic [NumBuses-1:0]   sda_phy_i;
  logic [NumBuses-1:0]   scl_pad_i;
  logic [NumBuses-1:0]   sda_pad_i;
  logic [NumBuses-1:0]   glitch_clr_i;
  logic [NumBuses-1:0]   scl_pad_o;
  logic [NumBuses-1:0]   sda_pad_o;
  logic [NumBuses-1:0]   scl_pad_oe_o;
  logic [NumBuses-1:0]   sda_pad_oe_o;
  logic [NumBuses-1:0]   scl_filt_o;
  logic [NumBuses-1:0]   sda_filt_o;
  logic [2*NumBuses-1:0] mode_o;
  logic [8*NumBuses-1:0] glitch_cnt_o;

  modport slave (
    input  bus_en_i, sel_od_pp_i, scl_phy_i, sda_phy_i, scl_pad_i, sda_pad_i, glitch_clr_i,
    output scl_pad_o, sda_pad_o, scl_pad_oe_o, sda_pad_oe_o, scl_filt_o, sda_filt_o,
           mode_o, glitch_cnt_o
  );

  modport master (
    output bus_en_i, sel_od_pp_i, scl_phy_i, sda_phy_i, scl_pad_i, sda_pad_i, glitch_clr_i,
    input  scl_pad_o, sda_pad_o, scl_pad_oe_o, sda_pad_oe_o, scl_filt_o, sda_filt_o,
           mode_o, glitch_cnt_o
  );
endinterface

// File: rtl/i3c_multi_bus_io.sv
// Multi-bus I3C pad glue: per-bus OD/PP/handoff drive FSM, synchronised glitch
// filters on SCL/SDA, and a saturating per-bus rejected-glitch counter.
module i3c_multi_bus_io #(
  parameter int NumBuses      = 2,
  parameter int SyncStages    = 2,
  parameter int FiltLen       = 3,
  parameter int HandoffCycles = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  i3c_multi_bus_io_if.slave io
);

  localparam int FCW = $clog2(FiltLen + 1);
  localparam int HCW = (HandoffCycles > 1) ? $clog2(HandoffCycles) : 1;
  localparam logic [FCW-1:0] FiltLast = FCW'(FiltLen - 1);
  localparam logic [HCW-1:0] HoLoad   = HCW'(HandoffCycles - 1);

  typedef enum logic [1:0] {
    MODE_OD = 2'd0,
    MODE_PP = 2'd1,
    MODE_HO = 2'd2
  } mode_e;

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Lines are interleaved: even index = SCL of bus l/2, odd index = SDA.
  logic [2*NumBuses-1:0] pad_raw;
  logic [2*NumBuses-1:0] filt;
  logic [2*NumBuses-1:0] rej;

  for (genvar l = 0; l < 2*NumBuses; l++) begin : g_line
    logic [SyncStages-1:0] sync_q;
    logic                  filt_q;
    logic [FCW-1:0]        cnt_q;
    logic                  sync_s;

    assign sync_s = sync_q[SyncStages-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '1;
        filt_q <= 1'b1;
        cnt_q  <= '0;
      end else begin
        sync_q <= {sync_q[SyncStages-2:0], pad_raw[l]};
        if (sync_s == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == FiltLast) begin
          filt_q <= sync_s;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + FCW'(1);
        end
      end
    end

    // A line that falls back to the accepted level mid-count was a glitch.
    assign rej[l]  = (sync_s == filt_q) && (cnt_q != '0);
    assign filt[l] = filt_q;
  end

  for (genvar b = 0; b < NumBuses; b++) begin : g_bus
    mode_e          state_q, state_d;
    logic [HCW-1:0] ho_q, ho_d;
    logic           scl_oe_d, scl_o_d, sda_oe_d, sda_o_d;
    logic           scl_oe_q, scl_o_q, sda_oe_q, sda_o_q;
    logic [7:0]     gcnt_q;
    logic           en, sel;

    assign en  = io.bus_en_i[b];
    assign sel = io.sel_od_pp_i[b];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q  <= MODE_OD;
        ho_q     <= '0;
        scl_oe_q <= 1'b0;
        scl_o_q  <= 1'b0;
        sda_oe_q <= 1'b0;
        sda_o_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        ho_q     <= ho_d;
        scl_oe_q <= scl_oe_d;
        scl_o_q  <= scl_o_d;
        sda_oe_q <= sda_oe_d;
        sda_o_q  <= sda_o_d;
      end
    end

    // Drive values follow the next state so mode and pads change on the same edge.
    always_comb begin
      state_d  = state_q;
      ho_d     = ho_q;
      scl_oe_d = 1'b0;
      scl_o_d  = 1'b0;
      sda_oe_d = 1'b0;
      sda_o_d  = 1'b0;
      if (!en) begin
        state_d = MODE_OD;
        ho_d    = '0;
      end else begin
        unique case (state_q)
          MODE_OD: if (sel) state_d = MODE_PP;
          MODE_PP: begin
            if (!sel) begin
              state_d = MODE_HO;
              ho_d    = HoLoad;
            end
          end
          MODE_HO: begin
            if (sel) begin
              state_d = MODE_PP;
              ho_d    = '0;
            end else if (ho_q == '0) begin
              state_d = MODE_OD;
            end else begin
              ho_d = ho_q - HCW'(1);
            end
          end
          default: state_d = MODE_OD;
        endcase
        if (state_d == MODE_OD) begin
          scl_oe_d = ~io.scl_phy_i[b];
          sda_oe_d = ~io.sda_phy_i[b];
        end else begin
          scl_oe_d = 1'b1;
          scl_o_d  = io.scl_phy_i[b];
          sda_oe_d = 1'b1;
          sda_o_d  = io.sda_phy_i[b];
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        gcnt_q <= '0;
      end else if (io.glitch_clr_i[b]) begin
        gcnt_q <= '0;
      end else begin
        gcnt_q <= sat_add(gcnt_q, 2'(rej[2*b]) + 2'(rej[2*b+1]));
      end
    end

    assign pad_raw[2*b]           = io.scl_pad_i[b];
    assign pad_raw[2*b+1]         = io.sda_pad_i[b];
    assign io.scl_filt_o[b]       = filt[2*b];
    assign io.sda_filt_o[b]       = filt[2*b+1];
    assign io.scl_pad_o[b]        = scl_o_q;
    assign io.sda_pad_o[b]        = sda_o_q;
    assign io.scl_pad_oe_o[b]     = scl_oe_q;
    assign io.sda_pad_oe_o[b]     = sda_oe_q;
    assign io.mode_o[2*b +: 2]    = state_q;
    assign io.glitch_cnt_o[8*b +: 8] = gcnt_q;
  end

endmodule

// File: doc/i3c_multi_bus_io.md
# i3c_multi_bus_io

Parametrised, multi-bus successor to the single-bus I3C pad glue. For each of `NumBuses` independent I3C buses it registers SCL and SDA pad drive with three modes: open-drain, push-pull, and a timed push-pull-to-open-drain handoff. It also synchronises and glitch-filters the pad inputs returned to the controller, and keeps per-bus counts of rejected glitches. It sits between the controller PHY signals and the pad ring.

## Interface
- `NumBuses`, 2, number of independent buses, ≥1
- `SyncStages`, 2, input synchroniser depth, ≥2
- `FiltLen`, 3, cycles a new synchronised level must persist before it is accepted, ≥1
- `HandoffCycles`, 2, push-pull hold cycles on a PP→OD switch, ≥1
- `clk_i` input 1 — single clock; all state on rising edge
- `rst_i` input 1 — reset is asynchronous and active-high
- `bus_en_i` input NumBuses — per-bus enable; 0 releases both lines
- `sel_od_pp_i` input NumBuses — requested mode; 1 = push-pull, 0 = open-drain
- `scl_phy_i`, `sda_phy_i` input NumBuses — requested line levels from the controller
- `scl_pad_i`, `sda_pad_i` input NumBuses — raw pad levels, asynchronous
- `scl_pad_o`, `sda_pad_o` output NumBuses — pad output value
- `scl_pad_oe_o`, `sda_pad_oe_o` output NumBuses — pad output enable; 0 = released (Hi-Z)
- `scl_filt_o`, `sda_filt_o` output NumBuses — synchronised, filtered line levels to the controller
- `mode_o` output 2*NumBuses — per-bus drive state: 0 = OD, 1 = PP, 2 = HANDOFF
- `glitch_cnt_o` output 8*NumBuses — per-bus saturating count of rejected glitches, SCL and SDA combined
- `glitch_clr_i` input NumBuses — synchronous clear of that bus's glitch count

## Operation
- Each bus has an identical, independent slice. Bus *b* uses bit *b* of every vector and bits [8b+7:8b] of `glitch_cnt_o`.
- Drive state machine, one per bus:
  - OD → PP when `bus_en_i`=1 and `sel_od_pp_i`=1.
  - PP → HANDOFF when `sel_od_pp_i`=0. The handoff counter loads `HandoffCycles`-1.
  - HANDOFF decrements the counter each cycle. HANDOFF → OD on the cycle the counter is 0.
  - HANDOFF → PP immediately if `sel_od_pp_i` returns to 1; the counter is discarded.
  - Any state → OD when `bus_en_i`=0. This takes priority over every other transition.
- Drive outputs are registered and computed from the next state and the current `*_phy_i`:
  - OD: `oe`=~phy, `pad_o`=0.
  - PP and HANDOFF: `oe`=1, `pad_o`=phy.
  - Bus disabled: `oe`=0, `pad_o`=0.
- Receive path, per line: `SyncStages` flops, then a glitch filter.
  - The filter holds `filt` and a counter `cnt` of width clog2(FiltLen+1).
  - If sync==filt: `cnt`←0. If `cnt`≠0, that is a rejected glitch.
  - Else, if `cnt`==FiltLen-1: `filt`←sync and `cnt`←0.
  - Else: `cnt`←cnt+1.
  - The receive path runs regardless of `bus_en_i`.
- Glitch count:
  - +1 per line rejection. If SCL and SDA reject in the same cycle, +2.
  - Saturates at 255.
  - `glitch_clr_i` has priority over a same-cycle increment; the result is 0.

## Timing
- Reset values: `*_pad_o`=0, `*_pad_oe_o`=0, `*_filt_o`=1, synchroniser flops=1, `mode_o`=0 (OD), all counters 0.
- Drive latency: 1 cycle from `*_phy_i`, `sel_od_pp_i` or `bus_en_i` to `pad_o`/`oe_o`/`mode_o`.
- PP→OD: after `sel_od_pp_i` falls, `mode_o`=HANDOFF for exactly `HandoffCycles` cycles, then OD. Lines keep driving actively throughout HANDOFF.
- OD→PP: 1 cycle; no intermediate state.
- Receive latency: a stable pad change reaches `*_filt_o` SyncStages+FiltLen cycles after the first sampling edge (5 at defaults). A pulse shorter than `FiltLen` synchronised cycles never reaches `*_filt_o`.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. On deassert, every bus starts in OD, released.

## Test plan
- Reset: assert `rst_i` mid-PP with `scl_phy_i`=0 → `scl_pad_oe_o`=0 and `mode_o`=0 without a clock edge; `*_filt_o`=1.
- Mode sequence, defaults: `sel_od_pp_i` 0→1 at T → `mode_o`=1 and `oe`=1 at T+1. `sel_od_pp_i` 1→0 at T+5 → `mode_o`=2 at T+6 and T+7, `mode_o`=0 at T+8, `oe`=~phy.
- Handoff abort: `sel_od_pp_i` back to 1 during the first HANDOFF cycle → `mode_o`=1 on the next cycle; no OD cycle appears.
- Glitch filter, FiltLen=3: 2-cycle low pulse on `sda_pad_i` → `sda_filt_o` stays 1 and `glitch_cnt_o` increments by 1. Stable low → `sda_filt_o`=0 after 5 cycles.
- Saturation/clear: 300 SCL glitches → count = 255. Simultaneous SCL+SDA glitch with `glitch_clr_i`=1 → count = 0.
- NumBuses=4: `bus_en_i`=4'b0101 with all buses requesting PP → only buses 0 and 2 report `mode_o`=1. Buses 1 and 3 keep `oe`=0 while their filters still track their pads.
